// File: rtl/gray_to_binary_serial.sv
// Serial-in Gray-code decoder: one Gray bit per handshake (MSB first), binary word out on
// a valid/ready port, with a +/-1 step check against the previously decoded word.
module gray_to_binary_serial #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sync_clr,
    input  logic         sin_bit,
    input  logic         sin_valid,
    output logic         sin_ready,
    output logic [W-1:0] bin_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         dir_up,
    output logic         step_err
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Step classification of a new word against the previous one: {dir_up, step_err}.
    function automatic logic [1:0] classify_step(input logic [W-1:0] cur,
                                                 input logic [W-1:0] prev,
                                                 input logic         prev_ok);
        logic [W-1:0] inc;
        logic [W-1:0] dec;
        logic [1:0]   res;
        inc = prev + W'(1);
        dec = prev - W'(1);
        if (!prev_ok) begin
            res = 2'b00;
        end else if (cur == inc) begin
            res = 2'b10;
        end else if (cur == dec) begin
            res = 2'b00;
        end else begin
            res = 2'b01;
        end
        return res;
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [W-1:0]  acc_r, acc_s;
    logic [W-1:0]  acc_upd_s;
    logic [W:0]    ext_s;
    logic [W-1:0]  bin_r, bin_s;
    logic          out_valid_r, out_valid_s;
    logic          dir_up_r, dir_up_s;
    logic          step_err_r, step_err_s;
    logic [W-1:0]  prev_word_r, prev_word_s;
    logic          prev_valid_r, prev_valid_s;
    logic          sin_ready_r;
    logic          last_bit_s;
    logic [1:0]    step_s;

    // Accumulator with the current bit folded in; the zero above the MSB makes bit W-1 plain.
    always_comb begin
        ext_s     = {1'b0, acc_r};
        acc_upd_s = acc_r;
        for (int i = 0; i < W; i++) begin
            if (int'(cnt_r) == (W - 1 - i)) begin
                acc_upd_s[i] = ext_s[i+1] ^ sin_bit;
            end else begin
                acc_upd_s[i] = acc_r[i];
            end
        end
        last_bit_s = (cnt_r == CW'(W - 1));
        step_s     = classify_step(acc_upd_s, prev_word_r, prev_valid_r);
    end

    // Next-state and datapath update; sync_clr overrides everything.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        acc_s        = acc_r;
        bin_s        = bin_r;
        out_valid_s  = out_valid_r;
        dir_up_s     = dir_up_r;
        step_err_s   = step_err_r;
        prev_word_s  = prev_word_r;
        prev_valid_s = prev_valid_r;
        if (sync_clr) begin
            state_s      = ST_COLLECT;
            cnt_s        = {CW{1'b0}};
            acc_s        = {W{1'b0}};
            out_valid_s  = 1'b0;
            prev_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (sin_valid) begin
                        acc_s = acc_upd_s;
                        if (last_bit_s) begin
                            cnt_s        = {CW{1'b0}};
                            bin_s        = acc_upd_s;
                            out_valid_s  = 1'b1;
                            dir_up_s     = step_s[1];
                            step_err_s   = step_s[0];
                            prev_word_s  = acc_upd_s;
                            prev_valid_s = 1'b1;
                            state_s      = ST_PRESENT;
                        end else begin
                            cnt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        acc_s = acc_r;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid_s = 1'b0;
                        state_s     = ST_COLLECT;
                    end else begin
                        out_valid_s = 1'b1;
                    end
                end
                default: begin
                    state_s     = ST_COLLECT;
                    cnt_s       = {CW{1'b0}};
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_COLLECT;
            cnt_r        <= {CW{1'b0}};
            acc_r        <= {W{1'b0}};
            bin_r        <= {W{1'b0}};
            out_valid_r  <= 1'b0;
            dir_up_r     <= 1'b0;
            step_err_r   <= 1'b0;
            prev_word_r  <= {W{1'b0}};
            prev_valid_r <= 1'b0;
            sin_ready_r  <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            acc_r        <= acc_s;
            bin_r        <= bin_s;
            out_valid_r  <= out_valid_s;
            dir_up_r     <= dir_up_s;
            step_err_r   <= step_err_s;
            prev_word_r  <= prev_word_s;
            prev_valid_r <= prev_valid_s;
            sin_ready_r  <= (state_s == ST_COLLECT);
        end
    end

    assign sin_ready = sin_ready_r;
    assign bin_out   = bin_r;
    assign out_valid = out_valid_r;
    assign dir_up    = dir_up_r;
    assign step_err  = step_err_r;

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Directed bench for gray_to_binary_serial (W=4): table of frames plus reset/sync_clr sequences.
module tb_gray_to_binary_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_clr;
    logic       sin_bit;
    logic       sin_valid;
    logic       sin_ready;
    logic [3:0] bin_out;
    logic       out_valid;
    logic       out_ready;
    logic       dir_up;
    logic       step_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic       dir;
        logic       err;
        logic       gap;
        int         hold;
    } vec_t;

    vec_t tbl[13];

    gray_to_binary_serial #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clr  (sync_clr),
        .sin_bit   (sin_bit),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dir_up    (dir_up),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives the 4 Gray bits MSB first, optionally with idle gaps, then stops offering.
    task automatic send_bits(input logic [3:0] g, input logic gap);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            if (gap && (i == 1)) begin
                sin_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
            chk("ready_collect", {31'd0, sin_ready}, 32'd1);
            sin_valid = 1'b1;
            sin_bit   = g[i];
        end
        @(negedge clk);
        sin_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [3:0] g, input logic [3:0] eb, input logic ed,
                             input logic ee, input logic gap, input int hold);
        send_bits(g, gap);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("bin_out", {28'd0, bin_out}, {28'd0, eb});
        chk("dir_up", {31'd0, dir_up}, {31'd0, ed});
        chk("step_err", {31'd0, step_err}, {31'd0, ee});
        for (int h = 0; h < hold; h++) begin
            sin_valid = 1'b1;
            sin_bit   = 1'b1;
            @(negedge clk);
            chk("hold_ready", {31'd0, sin_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_bin", {28'd0, bin_out}, {28'd0, eb});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        sin_valid = 1'b0;
        chk("consumed", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        //            gray     bin      dir   err   gap   hold
        tbl[0]  = '{4'b1101, 4'd9,  1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{4'b1111, 4'd10, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{4'b1101, 4'd9,  1'b0, 1'b0, 1'b1, 0};
        tbl[3]  = '{4'b1010, 4'd12, 1'b0, 1'b1, 1'b0, 0};
        tbl[4]  = '{4'b1010, 4'd12, 1'b0, 1'b1, 1'b0, 0};
        tbl[5]  = '{4'b1011, 4'd13, 1'b1, 1'b0, 1'b1, 0};
        tbl[6]  = '{4'b1000, 4'd15, 1'b0, 1'b1, 1'b0, 0};
        tbl[7]  = '{4'b0000, 4'd0,  1'b1, 1'b0, 1'b0, 0};
        tbl[8]  = '{4'b1000, 4'd15, 1'b0, 1'b0, 1'b0, 0};
        tbl[9]  = '{4'b0001, 4'd1,  1'b0, 1'b1, 1'b0, 0};
        tbl[10] = '{4'b0000, 4'd0,  1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{4'b0001, 4'd1,  1'b1, 1'b0, 1'b0, 5};
        tbl[12] = '{4'b0011, 4'd2,  1'b1, 1'b0, 1'b1, 0};

        rst_n     = 1'b0;
        sync_clr  = 1'b0;
        sin_bit   = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bin", {28'd0, bin_out}, 32'd0);
        chk("rst_dir", {31'd0, dir_up}, 32'd0);
        chk("rst_err", {31'd0, step_err}, 32'd0);
        chk("rst_ready", {31'd0, sin_ready}, 32'd1);

        for (int v = 0; v < 13; v++) begin
            run_frame(tbl[v].gray, tbl[v].bin, tbl[v].dir, tbl[v].err, tbl[v].gap, tbl[v].hold);
        end

        // Asynchronous reset mid-frame after two bits.
        @(negedge clk);
        sin_valid = 1'b1;
        sin_bit   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sin_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bin", {28'd0, bin_out}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_dir", {31'd0, dir_up}, 32'd0);
        chk("arst_ready", {31'd0, sin_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(4'b0110, 4'd4, 1'b0, 1'b0, 1'b0, 0);

        // sync_clr together with the third bit: bit dropped, previous word forgotten.
        @(negedge clk);
        sin_valid = 1'b1;
        sin_bit   = 1'b0;
        @(negedge clk);
        sin_bit = 1'b1;
        @(negedge clk);
        sin_bit  = 1'b1;
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr  = 1'b0;
        sin_valid = 1'b0;
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_ready", {31'd0, sin_ready}, 32'd1);
        run_frame(4'b0101, 4'd6, 1'b0, 1'b0, 1'b0, 0);

        // sync_clr while a word is pending in PRESENT discards it.
        send_bits(4'b0100, 1'b0);
        chk("pend_valid", {31'd0, out_valid}, 32'd1);
        chk("pend_bin", {28'd0, bin_out}, 32'd7);
        chk("pend_dir", {31'd0, dir_up}, 32'd1);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        chk("pclr_valid", {31'd0, out_valid}, 32'd0);
        chk("pclr_ready", {31'd0, sin_ready}, 32'd1);
        run_frame(4'b1101, 4'd9, 1'b0, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
